// File: rtl/mdc_pkg.sv
// Shared widths and FSM state type for the MDC stimulus encoder and its Hamming encoder.
package mdc_pkg;
  localparam int MAT_N   = 16;
  localparam int DATA_W  = 11;
  localparam int CODE_W  = 15;
  localparam int MODE_W  = 5;
  localparam int MCODE_W = 9;
  localparam int ERR_W   = 4;

  typedef enum logic [1:0] {IDLE, GAP, SEND, WAIT} state_t;
endpackage

// File: rtl/mdc_ham_enc.sv
// Combinational Hamming encoder (position 1 = MSB, parity at powers of two) with optional
// single-bit flip at a 1-based codeword position; out-of-range positions leave the code intact.
module mdc_ham_enc
  import mdc_pkg::*;
#(
  parameter int K  = DATA_W,
  parameter int N  = CODE_W,
  parameter int EW = ERR_W
) (
  input  logic [K-1:0]  data,
  input  logic [EW-1:0] err_pos,
  output logic [N-1:0]  code
);

  always_comb begin
    logic [N-1:0] c;
    int           di;
    logic         par;
    c   = '0;
    di  = K - 1;
    par = 1'b0;
    // Data bits go MSB first into every non-power-of-two position, ascending.
    for (int p = 1; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[N-p] = data[di];
        di     = di - 1;
      end
    end
    for (int b = 0; (1 << b) <= N; b++) begin
      par = 1'b0;
      for (int p = 1; p <= N; p++) begin
        if (p[b]) par = par ^ c[N-p];
      end
      c[N-(1<<b)] = par;
    end
    if (err_pos != '0 && int'(err_pos) <= N) c[N-int'(err_pos)] = ~c[N-int'(err_pos)];
    code = c;
  end

endmodule

// File: rtl/mdc_stim_encoder.sv
// Accepts one 4x4 matrix + mode, streams Hamming-encoded entries to the MDC over 16 cycles,
// then waits (bounded) for the core's out_valid before accepting the next transaction.
module mdc_stim_encoder
  import mdc_pkg::*;
#(
  parameter int GAP_CYCLES = 0,
  parameter int TIMEOUT    = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [MAT_N*DATA_W-1:0]   s_mat,
  input  logic [MODE_W-1:0]         s_mode,
  input  logic [MAT_N*ERR_W-1:0]    s_err_pos,
  input  logic [ERR_W-1:0]          s_mode_err,
  output logic                      in_valid,
  output logic [CODE_W-1:0]         in_data,
  output logic [MCODE_W-1:0]        in_mode,
  input  logic                      out_valid,
  output logic                      done,
  output logic                      timeout,
  output logic                      proto_err
);

  localparam int WCNT_W = $clog2(TIMEOUT + 1);

  state_t                    state_reg, state_next;
  logic [3:0]                idx_reg, idx_next;
  logic [3:0]                gap_cnt_reg, gap_cnt_next;
  logic [WCNT_W-1:0]         wait_cnt_reg, wait_cnt_next;
  logic [MAT_N*DATA_W-1:0]   mat_reg;
  logic [MODE_W-1:0]         mode_reg;
  logic [MAT_N*ERR_W-1:0]    err_reg;
  logic [ERR_W-1:0]          mode_err_reg;
  logic                      in_valid_reg, in_valid_next;
  logic [CODE_W-1:0]         in_data_reg, in_data_next;
  logic [MCODE_W-1:0]        in_mode_reg, in_mode_next;
  logic                      done_reg, done_next;
  logic                      timeout_reg, timeout_next;
  logic                      proto_err_reg, proto_err_next;

  logic [DATA_W-1:0]  entry     [MAT_N];
  logic [ERR_W-1:0]   entry_err [MAT_N];
  logic [CODE_W-1:0]  data_code;
  logic [MCODE_W-1:0] mode_code;

  for (genvar gi = 0; gi < MAT_N; gi++) begin : g_unpack
    assign entry[gi]     = mat_reg[DATA_W*gi +: DATA_W];
    assign entry_err[gi] = err_reg[ERR_W*gi +: ERR_W];
  end

  mdc_ham_enc #(.K(DATA_W), .N(CODE_W), .EW(ERR_W)) u_data_enc (
    .data    (entry[idx_reg]),
    .err_pos (entry_err[idx_reg]),
    .code    (data_code)
  );

  mdc_ham_enc #(.K(MODE_W), .N(MCODE_W), .EW(ERR_W)) u_mode_enc (
    .data    (mode_reg),
    .err_pos (mode_err_reg),
    .code    (mode_code)
  );

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    gap_cnt_next   = gap_cnt_reg;
    wait_cnt_next  = wait_cnt_reg;
    in_valid_next  = 1'b0;
    in_data_next   = '0;
    in_mode_next   = '0;
    done_next      = 1'b0;
    timeout_next   = 1'b0;
    proto_err_next = out_valid && (state_reg != WAIT);
    case (state_reg)
      IDLE: begin
        if (s_valid) begin
          idx_next     = '0;
          gap_cnt_next = '0;
          state_next   = (GAP_CYCLES > 0) ? GAP : SEND;
        end
      end
      GAP: begin
        if (gap_cnt_reg == 4'(GAP_CYCLES - 1)) state_next = SEND;
        else gap_cnt_next = gap_cnt_reg + 4'd1;
      end
      SEND: begin
        in_valid_next = 1'b1;
        in_data_next  = data_code;
        in_mode_next  = (idx_reg == '0) ? mode_code : '0;
        idx_next      = idx_reg + 4'd1;
        if (idx_reg == 4'(MAT_N - 1)) begin
          state_next    = WAIT;
          wait_cnt_next = WCNT_W'(1);
        end
      end
      WAIT: begin
        // A result arriving on the timeout cycle still counts as success.
        if (out_valid) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else if (wait_cnt_reg >= WCNT_W'(TIMEOUT)) begin
          state_next   = IDLE;
          timeout_next = 1'b1;
        end else if (wait_cnt_reg != '1) begin
          wait_cnt_next = wait_cnt_reg + WCNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      gap_cnt_reg   <= '0;
      wait_cnt_reg  <= '0;
      in_valid_reg  <= 1'b0;
      in_data_reg   <= '0;
      in_mode_reg   <= '0;
      done_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
      proto_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      gap_cnt_reg   <= gap_cnt_next;
      wait_cnt_reg  <= wait_cnt_next;
      in_valid_reg  <= in_valid_next;
      in_data_reg   <= in_data_next;
      in_mode_reg   <= in_mode_next;
      done_reg      <= done_next;
      timeout_reg   <= timeout_next;
      proto_err_reg <= proto_err_next;
    end
  end

  always_ff @(posedge clk) begin
    if (s_valid && state_reg == IDLE) begin
      mat_reg      <= s_mat;
      mode_reg     <= s_mode;
      err_reg      <= s_err_pos;
      mode_err_reg <= s_mode_err;
    end
  end

  assign s_ready   = (state_reg == IDLE);
  assign in_valid  = in_valid_reg;
  assign in_data   = in_data_reg;
  assign in_mode   = in_mode_reg;
  assign done      = done_reg;
  assign timeout   = timeout_reg;
  assign proto_err = proto_err_reg;

endmodule

// File: tb/tb_mdc_stim_encoder.sv
// Self-checking bench: table-driven codeword vectors through a scoreboard queue, plus
// hand-written sequences for latency, gap, timeout, done-vs-timeout, proto_err and reset abort.
module tb_mdc_stim_encoder;

  typedef struct {
    logic [10:0] d;
    logic [3:0]  e;
    logic [14:0] code;
  } vec_t;

  typedef struct {
    logic [14:0] data;
    logic [8:0]  mode;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid_a, s_valid_b, out_valid_a, out_valid_b;
  logic [175:0] s_mat;
  logic [4:0]   s_mode;
  logic [63:0]  s_err_pos;
  logic [3:0]   s_mode_err;
  logic         s_ready_a, in_valid_a, done_a, timeout_a, proto_err_a;
  logic         s_ready_b, in_valid_b, done_b, timeout_b, proto_err_b;
  logic [14:0]  in_data_a, in_data_b;
  logic [8:0]   in_mode_a, in_mode_b;

  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  vec_t tbl[16];

  always #5 clk = ~clk;

  mdc_stim_encoder #(.GAP_CYCLES(0), .TIMEOUT(20)) dut_a (
    .clk(clk), .rst(rst), .s_valid(s_valid_a), .s_ready(s_ready_a), .s_mat(s_mat),
    .s_mode(s_mode), .s_err_pos(s_err_pos), .s_mode_err(s_mode_err), .in_valid(in_valid_a),
    .in_data(in_data_a), .in_mode(in_mode_a), .out_valid(out_valid_a), .done(done_a),
    .timeout(timeout_a), .proto_err(proto_err_a)
  );

  mdc_stim_encoder #(.GAP_CYCLES(3), .TIMEOUT(20)) dut_b (
    .clk(clk), .rst(rst), .s_valid(s_valid_b), .s_ready(s_ready_b), .s_mat(s_mat),
    .s_mode(s_mode), .s_err_pos(s_err_pos), .s_mode_err(s_mode_err), .in_valid(in_valid_b),
    .in_data(in_data_b), .in_mode(in_mode_b), .out_valid(out_valid_b), .done(done_b),
    .timeout(timeout_b), .proto_err(proto_err_b)
  );

  // Reference model: parity bits are the bits of the XOR of all set data positions.
  function automatic logic [14:0] model_data(input logic [10:0] d, input logic [3:0] e);
    int          pos [11];
    logic [1:15] cw;
    int          syn;
    pos = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
    cw  = '0;
    syn = 0;
    for (int i = 0; i < 11; i++) begin
      if (d[10-i]) begin
        cw[pos[i]] = 1'b1;
        syn = syn ^ pos[i];
      end
    end
    cw[1] = syn[0]; cw[2] = syn[1]; cw[4] = syn[2]; cw[8] = syn[3];
    if (e != 0) cw[e] = ~cw[e];
    return cw;
  endfunction

  function automatic logic [8:0] model_mode(input logic [4:0] m, input logic [3:0] e);
    int         pos [5];
    logic [1:9] cw;
    int         syn;
    pos = '{3, 5, 6, 7, 9};
    cw  = '0;
    syn = 0;
    for (int i = 0; i < 5; i++) begin
      if (m[4-i]) begin
        cw[pos[i]] = 1'b1;
        syn = syn ^ pos[i];
      end
    end
    cw[1] = syn[0]; cw[2] = syn[1]; cw[4] = syn[2]; cw[8] = syn[3];
    if (e != 0 && e <= 9) cw[e] = ~cw[e];
    return cw;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_rand();
    for (int i = 0; i < 16; i++) begin
      s_mat[11*i +: 11]  = 11'($urandom);
      s_err_pos[4*i +: 4] = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic push_exp(input logic [8:0] mexp);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      e.data = model_data(s_mat[11*i +: 11], s_err_pos[4*i +: 4]);
      e.mode = (i == 0) ? mexp : 9'h000;
      exp_q.push_back(e);
    end
  endtask

  // Returns one #1 after the accepting edge.
  task automatic offer(input bit to_b);
    bit rdy;
    rdy = 0;
    for (int i = 0; i < 60; i++) begin
      rdy = to_b ? s_ready_b : s_ready_a;
      if (rdy) break;
      @(negedge clk);
    end
    if (!rdy) begin
      checks++;
      failures++;
      $display("FAIL offer_ready: got s_ready=0 expected 1 within 60 cycles");
    end
    if (to_b) s_valid_b = 1'b1; else s_valid_a = 1'b1;
    @(posedge clk);
    #1;
    s_valid_a = 1'b0;
    s_valid_b = 1'b0;
    $display("txn offered to dut_%s mode=%b mode_err=%0d", to_b ? "b" : "a", s_mode, s_mode_err);
  endtask

  // n counts cycles after the last in_valid; out_valid is pulsed when n == pulse_n.
  task automatic run_wait(input int pulse_n, input bit exp_done);
    bit seen, hit;
    int n;
    seen = 0; hit = 0; n = 0;
    for (int i = 0; i < 80 && !hit; i++) begin
      @(negedge clk);
      if (in_valid_a) begin
        seen = 1; n = 0;
      end else if (seen) begin
        n++;
      end
      if (done_a || timeout_a) hit = 1;
      out_valid_a = (seen && !in_valid_a && n == pulse_n && !hit);
    end
    out_valid_a = 1'b0;
    if (exp_done) begin
      chk("done_latency", n, pulse_n + 1);
      chk("done_pulse", done_a, 1);
      chk("done_no_timeout", timeout_a, 0);
    end else begin
      chk("timeout_latency", n, 20);
      chk("timeout_pulse", timeout_a, 1);
      chk("timeout_no_done", done_a, 0);
    end
    chk("ready_after_wait", s_ready_a, 1);
    $display("txn finished: done=%0b timeout=%0b cycles_after_stream=%0d", done_a, timeout_a, n);
    @(negedge clk);
    chk("done_one_cycle", done_a, 0);
    chk("timeout_one_cycle", timeout_a, 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (in_valid_a) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL stream_extra: got in_data=%h expected no in_valid", in_data_a);
        end else begin
          mon_e = exp_q.pop_front();
          chk("stream_data", in_data_a, mon_e.data);
          chk("stream_mode", in_mode_a, mon_e.mode);
        end
      end else begin
        chk("idle_zero", {in_data_a, in_mode_a}, 0);
      end
    end
  end

  initial begin
    int   first, nhigh;
    bit   rdy_bad;
    exp_t e;
    rst = 1'b1;
    s_valid_a = 0; s_valid_b = 0; out_valid_a = 0; out_valid_b = 0;
    s_mat = '0; s_mode = '0; s_err_pos = '0; s_mode_err = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", s_ready_a, 1);
    chk("reset_ready_b", s_ready_b, 1);
    chk("reset_outputs", {in_valid_a, in_data_a, in_mode_a}, 0);
    chk("reset_pulses", {done_a, timeout_a, proto_err_a}, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    out_valid_a = 1'b1;
    @(negedge clk);
    out_valid_a = 1'b0;
    chk("proto_idle", proto_err_a, 1);
    chk("proto_idle_ready", s_ready_a, 1);
    @(negedge clk);
    chk("proto_one_cycle", proto_err_a, 0);

    // Transaction 1: codeword vector table packed into one matrix.
    tbl[0] = '{d: 11'h7FF, e: 4'd0,  code: 15'h7FFF};
    tbl[1] = '{d: 11'h001, e: 4'd0,  code: 15'h6881};
    tbl[2] = '{d: 11'h000, e: 4'd0,  code: 15'h0000};
    tbl[3] = '{d: 11'h000, e: 4'd15, code: 15'h0001};
    tbl[4] = '{d: 11'h7FF, e: 4'd3,  code: 15'h6FFF};
    for (int i = 5; i < 16; i++) begin
      tbl[i].d    = 11'($urandom);
      tbl[i].e    = 4'($urandom_range(0, 15));
      tbl[i].code = model_data(tbl[i].d, tbl[i].e);
    end
    for (int i = 0; i < 16; i++) begin
      s_mat[11*i +: 11]   = tbl[i].d;
      s_err_pos[4*i +: 4] = tbl[i].e;
      e.data = tbl[i].code;
      e.mode = (i == 0) ? 9'h0A8 : 9'h000;
      exp_q.push_back(e);
    end
    s_mode = 5'b00100;
    s_mode_err = 4'd0;
    offer(0);
    @(negedge clk);
    chk("latency_k", in_valid_a, 0);
    chk("ready_low_after_accept", s_ready_a, 0);
    @(negedge clk);
    chk("latency_k1", in_valid_a, 1);
    out_valid_a = 1'b1;
    @(negedge clk);
    out_valid_a = 1'b0;
    chk("proto_send", proto_err_a, 1);
    @(negedge clk);
    chk("proto_send_clear", proto_err_a, 0);
    run_wait(3, 1);

    // Transaction 2: all-ones matrix, mode flip position out of range, no result -> timeout.
    s_mat = '1;
    s_err_pos = '0;
    s_mode_err = 4'd12;
    for (int i = 0; i < 16; i++) begin
      e.data = 15'h7FFF;
      e.mode = (i == 0) ? 9'h0A8 : 9'h000;
      exp_q.push_back(e);
    end
    offer(0);
    run_wait(-1, 0);

    // Transaction 3: result arrives on the same cycle the timeout would fire.
    load_rand();
    s_mode_err = 4'd9;
    push_exp(9'h0A9);
    offer(0);
    run_wait(19, 1);

    // Transaction 4: reset while entry 7 is on the bus.
    load_rand();
    s_mode_err = 4'd1;
    push_exp(9'h1A8);
    offer(0);
    repeat (9) @(negedge clk);
    chk("pre_reset_streaming", in_valid_a, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_abort_valid", in_valid_a, 0);
    chk("reset_abort_ready", s_ready_a, 1);
    exp_q.delete();
    rst = 1'b0;

    // Transaction 5: fresh stream after the abort must start at entry 0.
    load_rand();
    s_mode = 5'($urandom);
    s_mode_err = 4'($urandom_range(0, 15));
    push_exp(model_mode(s_mode, s_mode_err));
    offer(0);
    run_wait(2, 1);

    // GAP_CYCLES=3 instance: first in_valid 4 cycles after accept, s_ready held low until done.
    load_rand();
    offer(1);
    first = -1; nhigh = 0; rdy_bad = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (in_valid_b) begin
        if (first < 0) begin
          first = n;
          chk("gap_first_data", in_data_b, model_data(s_mat[10:0], s_err_pos[3:0]));
        end
        nhigh++;
      end
      if (s_ready_b) rdy_bad = 1;
    end
    chk("gap_latency", first, 4);
    chk("gap_stream_len", nhigh, 16);
    chk("gap_ready_low", rdy_bad, 0);
    out_valid_b = 1'b1;
    @(negedge clk);
    out_valid_b = 1'b0;
    chk("gap_done", done_b, 1);
    chk("gap_ready_back", s_ready_b, 1);
    $display("txn finished on dut_b: first_valid=%0d beats=%0d", first, nhigh);

    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
